mult_add_npairs_acc: RTL and testbench

Parametrised, pipelined N-pair multiply-add with frame accumulation and valid/ready flow control, for the fully-connected layers. Each accepted beat carries NUM_PAIRS operand pairs. The block multiplies each pair, sums the products through a registered adder tree, and accumulates beats until a beat marked last. It then presents one result per frame. It replaces the fixed 2- and 5-pair multiply-add chains.

---
 rtl/mult_add_pkg.sv | 52 +++++
 rtl/parl_add_tree.sv | 89 ++++++++
 rtl/mult_add_npairs_acc.sv | 204 ++++++++++++++++++++
 tb/tb_mult_add_npairs_acc.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_add_pkg.sv
// mult_add_pkg: shared width helpers and operand type for mult_add_npairs_acc
// and its adder tree.
// Build option: MULT_ADD_SIGNED_EN selects two's-complement operands and sign
// extension throughout; when undefined everything is unsigned/zero-extended.
package mult_add_pkg;

`ifdef MULT_ADD_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   // Operand type at the default operand width, for code that handles single
   // operands outside the packed beat buses.
   localparam int OPERAND_W_DEFAULT = 8;
`ifdef MULT_ADD_SIGNED_EN
   typedef logic signed [OPERAND_W_DEFAULT-1:0] operand_t;
`else
   typedef logic [OPERAND_W_DEFAULT-1:0] operand_t;
`endif

   // Width of one product.
   function automatic int prod_w(input int ow);
      return 2 * ow;
   endfunction

   // Registered adder-tree levels for n leaves (0 for a single leaf).
   function automatic int tree_stages(input int n);
      return (n > 1) ? $clog2(n) : 0;
   endfunction

   // Width of the adder-tree sum: one extra bit per level.
   function automatic int tree_w(input int ow, input int n);
      return prod_w(ow) + tree_stages(n);
   endfunction

   // Result width: room for MAX_BEATS full beats plus one guard bit.
   function automatic int out_w(input int ow, input int n, input int mb);
      return 2 * ow + $clog2(n) + $clog2(mb) + 1;
   endfunction

   // Number of nodes at a given tree level (level 0 = leaves).
   function automatic int level_count(input int n, input int lvl);
      int c;
      c = n;
      for (int i = 0; i < lvl; i++) begin
         c = (c + 1) / 2;
      end
      return c;
   endfunction

endpackage

// File: rtl/parl_add_tree.sv
// parl_add_tree: registered binary adder tree over NUM_LEAVES leaves.
// Each level adds adjacent pairs, widening by one bit; an odd leftover node is
// extended and registered through unchanged. valid/last ride alongside the data
// and every register advances only when en=1.
// Build option: MULT_ADD_SIGNED_EN selects sign extension (via mult_add_pkg).
module parl_add_tree
   import mult_add_pkg::*;
#(
   parameter int NUM_LEAVES = 5,
   parameter int LEAF_W     = 16
) (
   input  logic                                         clk,
   input  logic                                         rst_b,
   input  logic                                         en,
   input  logic                                         in_valid,
   input  logic                                         in_last,
   input  logic [NUM_LEAVES*LEAF_W-1:0]                 leaves,
   output logic [LEAF_W+tree_stages(NUM_LEAVES)-1:0]    sum,
   output logic                                         out_valid,
   output logic                                         out_last
);

   localparam int STAGES = tree_stages(NUM_LEAVES);

   genvar gi, gj;
   generate
      for (gi = 0; gi <= STAGES; gi++) begin : g_lvl
         localparam int CNT = level_count(NUM_LEAVES, gi);
         localparam int W   = LEAF_W + gi;

         logic [CNT*W-1:0] node_flat;
         logic             valid;
         logic             last;

         if (gi == 0) begin : g_leaf
            assign node_flat = leaves;
            assign valid     = in_valid;
            assign last      = in_last;
         end else begin : g_add
            localparam int PCNT = level_count(NUM_LEAVES, gi - 1);
            localparam int PW   = W - 1;

            for (gj = 0; gj < CNT; gj++) begin : g_node
               logic [PW-1:0] lhs;
               logic [W-1:0]  node_next;
               logic [W-1:0]  node_reg;

               assign lhs = g_lvl[gi-1].node_flat[2*gj*PW +: PW];

               if (2 * gj + 1 < PCNT) begin : g_pair
                  logic [PW-1:0] rhs;
                  assign rhs       = g_lvl[gi-1].node_flat[(2*gj+1)*PW +: PW];
                  assign node_next = {SIGNED_EN & lhs[PW-1], lhs}
                                   + {SIGNED_EN & rhs[PW-1], rhs};
               end else begin : g_pass
                  assign node_next = {SIGNED_EN & lhs[PW-1], lhs};
               end

               // One tree node: register the pair sum (or the passed-through leftover).
               always_ff @(posedge clk or negedge rst_b) begin
                  if (!rst_b) begin
                     node_reg <= '0;
                  end else if (en) begin
                     node_reg <= node_next;
                  end
               end

               assign node_flat[gj*W +: W] = node_reg;
            end

            // Sidebands follow the data through this level.
            always_ff @(posedge clk or negedge rst_b) begin
               if (!rst_b) begin
                  valid <= 1'b0;
                  last  <= 1'b0;
               end else if (en) begin
                  valid <= g_lvl[gi-1].valid;
                  last  <= g_lvl[gi-1].last;
               end
            end
         end
      end
   endgenerate

   assign sum       = g_lvl[STAGES].node_flat;
   assign out_valid = g_lvl[STAGES].valid;
   assign out_last  = g_lvl[STAGES].last;

endmodule

// File: rtl/mult_add_npairs_acc.sv
// mult_add_npairs_acc: pipelined NUM_PAIRS multiply-add with frame accumulation.
// Pipeline: M (products) -> T (adder tree) -> S (sum aligned to result width)
// -> A (accumulator, beat counter, output register). A single global enable
// (pipe_en) stalls every stage together whenever a result waits unconsumed.
// Build option: MULT_ADD_SIGNED_EN selects signed operands and arithmetic.
module mult_add_npairs_acc
   import mult_add_pkg::*;
#(
   parameter int OPERAND_WIDTH = 8,
   parameter int NUM_PAIRS     = 5,
   parameter int MAX_BEATS     = 16,
   parameter int OUTPUT_WIDTH  = out_w(OPERAND_WIDTH, NUM_PAIRS, MAX_BEATS)
) (
   input  logic                               macc_clk,
   input  logic                               macc_rst_b,
   input  logic                               macc_in_valid_i,
   output logic                               macc_in_ready_o,
   input  logic                               macc_in_last_i,
   input  logic [NUM_PAIRS*OPERAND_WIDTH-1:0] macc_in_a_i,
   input  logic [NUM_PAIRS*OPERAND_WIDTH-1:0] macc_in_b_i,
   output logic                               macc_out_valid_o,
   input  logic                               macc_out_ready_i,
   output logic [OUTPUT_WIDTH-1:0]            macc_out_data_o,
   output logic                               macc_out_ovf_o
);

   localparam int PROD_W = prod_w(OPERAND_WIDTH);
   localparam int TREE_W = tree_w(OPERAND_WIDTH, NUM_PAIRS);
   localparam int CNT_W  = $clog2(MAX_BEATS + 2);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_BEATS);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_BEATS + 1);

   // ------------------------------------------------------------------
   // Flow control: the whole pipe moves unless a result is waiting.
   // ------------------------------------------------------------------
   logic out_valid_reg;
   logic pipe_en;

   assign pipe_en         = ~out_valid_reg | macc_out_ready_i;
   assign macc_in_ready_o = pipe_en;

   // ------------------------------------------------------------------
   // Stage M: one product per pair. Operands are extended to the product
   // width first so a plain truncating multiply is exact in both builds.
   // ------------------------------------------------------------------
   logic [NUM_PAIRS*PROD_W-1:0] prod_next;
   logic [NUM_PAIRS*PROD_W-1:0] prod_reg;
   logic                        m_valid_reg;
   logic                        m_last_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PAIRS; gi++) begin : g_mult
         logic [OPERAND_WIDTH-1:0] a_op;
         logic [OPERAND_WIDTH-1:0] b_op;
         logic [PROD_W-1:0]        a_ext;
         logic [PROD_W-1:0]        b_ext;

         assign a_op  = macc_in_a_i[gi*OPERAND_WIDTH +: OPERAND_WIDTH];
         assign b_op  = macc_in_b_i[gi*OPERAND_WIDTH +: OPERAND_WIDTH];
         assign a_ext = {{OPERAND_WIDTH{SIGNED_EN & a_op[OPERAND_WIDTH-1]}}, a_op};
         assign b_ext = {{OPERAND_WIDTH{SIGNED_EN & b_op[OPERAND_WIDTH-1]}}, b_op};
         assign prod_next[gi*PROD_W +: PROD_W] = a_ext * b_ext;
      end
   endgenerate

   // Product register with its valid/last sidebands.
   always_ff @(posedge macc_clk or negedge macc_rst_b) begin
      if (!macc_rst_b) begin
         prod_reg    <= '0;
         m_valid_reg <= 1'b0;
         m_last_reg  <= 1'b0;
      end else if (pipe_en) begin
         prod_reg    <= prod_next;
         m_valid_reg <= macc_in_valid_i;
         m_last_reg  <= macc_in_last_i;
      end
   end

   // ------------------------------------------------------------------
   // Stage T: registered adder tree.
   // ------------------------------------------------------------------
   logic [TREE_W-1:0] tree_sum;
   logic              t_valid;
   logic              t_last;

   parl_add_tree #(
      .NUM_LEAVES (NUM_PAIRS),
      .LEAF_W     (PROD_W)
   ) u_tree (
      .clk       (macc_clk),
      .rst_b     (macc_rst_b),
      .en        (pipe_en),
      .in_valid  (m_valid_reg),
      .in_last   (m_last_reg),
      .leaves    (prod_reg),
      .sum       (tree_sum),
      .out_valid (t_valid),
      .out_last  (t_last)
   );

   // ------------------------------------------------------------------
   // Stage S: beat sum extended to the result width, so the accumulator
   // adder sees a register on both inputs.
   // ------------------------------------------------------------------
   logic [OUTPUT_WIDTH-1:0] sum_ext;
   logic [OUTPUT_WIDTH-1:0] s_sum_reg;
   logic                    s_valid_reg;
   logic                    s_last_reg;

   assign sum_ext = {{(OUTPUT_WIDTH-TREE_W){SIGNED_EN & tree_sum[TREE_W-1]}}, tree_sum};

   // Aligned beat-sum register with sidebands.
   always_ff @(posedge macc_clk or negedge macc_rst_b) begin
      if (!macc_rst_b) begin
         s_sum_reg   <= '0;
         s_valid_reg <= 1'b0;
         s_last_reg  <= 1'b0;
      end else if (pipe_en) begin
         s_sum_reg   <= sum_ext;
         s_valid_reg <= t_valid;
         s_last_reg  <= t_last;
      end
   end

   // ------------------------------------------------------------------
   // Stage A: accumulator, beat counter and overflow tracking.
   // The counter holds the number of beats already accumulated in the
   // open frame, so a beat arriving while it equals MAX_BEATS is the
   // first one beyond the guaranteed-exact length.
   // ------------------------------------------------------------------
   logic [OUTPUT_WIDTH-1:0] acc_reg;
   logic [CNT_W-1:0]        beat_cnt_reg;
   logic                    ovf_sticky_reg;
   logic                    acc_empty_reg;
   logic [OUTPUT_WIDTH-1:0] acc_sum;
   logic [CNT_W-1:0]        cnt_next;
   logic                    beat_ovf;
   logic                    beat_take;
   logic                    frame_close;

   assign beat_take   = pipe_en & s_valid_reg;
   assign frame_close = beat_take & s_last_reg;

   // Running sum, saturating counter and overflow flag for the current beat.
   always_comb begin
      acc_sum  = (acc_empty_reg ? '0 : acc_reg) + s_sum_reg;
      beat_ovf = ovf_sticky_reg | (beat_cnt_reg == CNT_FULL);
      cnt_next = beat_cnt_reg;
      if (beat_cnt_reg != CNT_SAT) begin
         cnt_next = beat_cnt_reg + CNT_W'(1);
      end
   end

   // Accumulate mid-frame beats; clear everything when a frame closes.
   always_ff @(posedge macc_clk or negedge macc_rst_b) begin
      if (!macc_rst_b) begin
         acc_reg        <= '0;
         beat_cnt_reg   <= '0;
         ovf_sticky_reg <= 1'b0;
         acc_empty_reg  <= 1'b1;
      end else if (beat_take) begin
         if (s_last_reg) begin
            acc_reg        <= '0;
            beat_cnt_reg   <= '0;
            ovf_sticky_reg <= 1'b0;
            acc_empty_reg  <= 1'b1;
         end else begin
            acc_reg        <= acc_sum;
            beat_cnt_reg   <= cnt_next;
            ovf_sticky_reg <= beat_ovf;
            acc_empty_reg  <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Output register: holds while stalled, reloads on a closing beat,
   // otherwise drops valid once the result has been taken.
   // ------------------------------------------------------------------
   logic [OUTPUT_WIDTH-1:0] out_data_reg;
   logic                    out_ovf_reg;

   // Result hand-off register.
   always_ff @(posedge macc_clk or negedge macc_rst_b) begin
      if (!macc_rst_b) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_ovf_reg   <= 1'b0;
      end else if (pipe_en) begin
         out_valid_reg <= frame_close;
         if (frame_close) begin
            out_data_reg <= acc_sum;
            out_ovf_reg  <= beat_ovf;
         end
      end
   end

   assign macc_out_valid_o = out_valid_reg;
   assign macc_out_data_o  = out_data_reg;
   assign macc_out_ovf_o   = out_ovf_reg;

endmodule

// File: tb/tb_mult_add_npairs_acc.sv
// tb_mult_add_npairs_acc: self-checking bench for mult_add_npairs_acc.
// A frame-level model (dot products summed per frame, ovf when the frame has
// more than MAX_BEATS beats) feeds an expected-result queue; one compare
// process checks every consumed result, the ready rule and output stability.
// Directed frames pin the model with hand-computed literals; a randomized
// phase mixes bubbles, back-pressure and overflowing frames.
// Build option: MULT_ADD_SIGNED_EN switches the model and literals to signed.
`timescale 1ns/1ps
module tb_mult_add_npairs_acc;

   localparam int OW   = 8;
   localparam int NP   = 5;
   localparam int MB   = 4;
   localparam int OUTW = 2 * OW + $clog2(NP) + $clog2(MB) + 1;
   localparam int LAT  = 2 + $clog2(NP);

   typedef struct {
      logic [OUTW-1:0] data;
      logic            ovf;
   } res_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic             in_last;
   logic [NP*OW-1:0] in_a;
   logic [NP*OW-1:0] in_b;
   logic             out_valid;
   logic             out_ready;
   logic [OUTW-1:0]  out_data;
   logic             out_ovf;

   int     checks = 0;
   int     errors = 0;
   res_t   exp_q[$];
   res_t   got_q[$];
   longint frame_sum = 0;
   int     frame_beats = 0;
   logic   stall_hold = 1'b0;
   res_t   held;
   logic   rand_done = 1'b0;

   always #5 clk = ~clk;

   mult_add_npairs_acc #(
      .OPERAND_WIDTH (OW),
      .NUM_PAIRS     (NP),
      .MAX_BEATS     (MB),
      .OUTPUT_WIDTH  (OUTW)
   ) dut (
      .macc_clk         (clk),
      .macc_rst_b       (rst_n),
      .macc_in_valid_i  (in_valid),
      .macc_in_ready_o  (in_ready),
      .macc_in_last_i   (in_last),
      .macc_in_a_i      (in_a),
      .macc_in_b_i      (in_b),
      .macc_out_valid_o (out_valid),
      .macc_out_ready_i (out_ready),
      .macc_out_data_o  (out_data),
      .macc_out_ovf_o   (out_ovf)
   );

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Dot product of one beat, as plain integer arithmetic.
   function automatic longint beat_dot(input logic [NP*OW-1:0] a, input logic [NP*OW-1:0] b);
      longint s;
      longint x;
      longint y;
      s = 0;
      for (int i = 0; i < NP; i++) begin
`ifdef MULT_ADD_SIGNED_EN
         x = longint'($signed(a[i*OW +: OW]));
         y = longint'($signed(b[i*OW +: OW]));
`else
         x = longint'(a[i*OW +: OW]);
         y = longint'(b[i*OW +: OW]);
`endif
         s += x * y;
      end
      return s;
   endfunction

   function automatic logic [NP*OW-1:0] splat(input logic [OW-1:0] v);
      logic [NP*OW-1:0] p;
      for (int i = 0; i < NP; i++) p[i*OW +: OW] = v;
      return p;
   endfunction

   function automatic logic [NP*OW-1:0] pack5(input int v0, input int v1, input int v2,
                                              input int v3, input int v4);
      int               v [5];
      logic [NP*OW-1:0] p;
      v = '{v0, v1, v2, v3, v4};
      p = '0;
      for (int i = 0; i < NP; i++) p[i*OW +: OW] = v[i][OW-1:0];
      return p;
   endfunction

   // Model + compare: sampled on the falling edge, when everything is stable.
   always @(negedge clk) begin
      res_t r;
      logic [63:0] s_bits;
      if (!rst_n) begin
         frame_sum   = 0;
         frame_beats = 0;
         exp_q.delete();
         stall_hold  = 1'b0;
      end else begin
         check("in_ready_rule", in_ready, (!out_valid) || out_ready);
         if (stall_hold) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, held.data);
            check("hold_ovf", out_ovf, held.ovf);
         end
         stall_hold = out_valid && !out_ready;
         held.data  = out_data;
         held.ovf   = out_ovf;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", 1, 0);
            end else begin
               r = exp_q.pop_front();
               check("result_data", out_data, r.data);
               check("result_ovf", out_ovf, r.ovf);
            end
            r.data = out_data;
            r.ovf  = out_ovf;
            got_q.push_back(r);
         end
         if (in_valid && in_ready) begin
            frame_sum += beat_dot(in_a, in_b);
            frame_beats++;
            if (in_last) begin
               s_bits = frame_sum;
               r.data = s_bits[OUTW-1:0];
               r.ovf  = (frame_beats > MB);
               exp_q.push_back(r);
               frame_sum   = 0;
               frame_beats = 0;
            end
         end
      end
   end

   // Present one beat and hold it until accepted; returns just after the accepting edge.
   task automatic drive_beat(input logic [NP*OW-1:0] a, input logic [NP*OW-1:0] b, input logic last);
      int waited;
      waited   = 0;
      in_a     = a;
      in_b     = b;
      in_last  = last;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) check("beat_accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_got(input int n, input string name);
      int t;
      t = 0;
      while (got_q.size() < n && t < 300) begin
         @(posedge clk);
         t++;
      end
      #1;
      if (got_q.size() < n) check(name, got_q.size(), n);
   endtask

   task automatic check_reset_values(input string tag);
      @(negedge clk);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_data"}, out_data, 0);
      check({tag, "_out_ovf"}, out_ovf, 0);
      check({tag, "_in_ready"}, in_ready, 1);
   endtask

   // Random back-pressure during the randomized phase.
   task automatic ready_toggler();
      while (!rand_done) begin
         @(posedge clk);
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
      out_ready = 1'b1;
   endtask

   task automatic random_frames(input int n_frames);
      logic [63:0] ra;
      logic [63:0] rb;
      int          len;
      for (int f = 0; f < n_frames; f++) begin
         len = $urandom_range(1, MB + 2);
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            drive_beat(ra[NP*OW-1:0], rb[NP*OW-1:0], (k == len - 1));
         end
      end
      rand_done = 1'b1;
   endtask

   initial begin
      int lat;
      int t;
      logic [OUTW-1:0] exp_v;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;

      repeat (3) @(posedge clk);
      check_reset_values("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2);

`ifndef MULT_ADD_SIGNED_EN
      // One-beat frame, plus exact latency from the accepting edge.
      got_q.delete();
      drive_beat(pack5(1, 2, 3, 4, 5), splat(8'd10), 1'b1);
      lat = 0;
      while (lat < 20) begin
         @(negedge clk);
         if (out_valid) break;
         @(posedge clk);
         lat++;
      end
      check("latency", lat, LAT);
      wait_got(1, "t1_timeout");
      if (got_q.size() >= 1) begin
         check("t1_data", got_q[0].data, 150);
         check("t1_ovf", got_q[0].ovf, 0);
      end

      // Three full-scale beats, then an all-zero frame back to back.
      got_q.delete();
      drive_beat(splat(8'd255), splat(8'd255), 1'b0);
      drive_beat(splat(8'd255), splat(8'd255), 1'b0);
      drive_beat(splat(8'd255), splat(8'd255), 1'b1);
      drive_beat(splat(8'd0), splat(8'd0), 1'b1);
      wait_got(2, "t2_timeout");
      if (got_q.size() >= 2) begin
         check("t2_data0", got_q[0].data, 975375);
         check("t2_ovf0", got_q[0].ovf, 0);
         check("t2_data1", got_q[1].data, 0);
      end

      // Frame of MAX_BEATS+1 unit beats overflows; MAX_BEATS beats does not.
      got_q.delete();
      for (int k = 0; k < MB + 1; k++) drive_beat(splat(8'd1), splat(8'd1), (k == MB));
      for (int k = 0; k < MB; k++) drive_beat(splat(8'd1), splat(8'd1), (k == MB - 1));
      wait_got(2, "t5_timeout");
      if (got_q.size() >= 2) begin
         check("t5_data0", got_q[0].data, 5 * (MB + 1));
         check("t5_ovf0", got_q[0].ovf, 1);
         check("t5_data1", got_q[1].data, 5 * MB);
         check("t5_ovf1", got_q[1].ovf, 0);
      end
`else
      // Signed mixed-sign frame.
      got_q.delete();
      drive_beat(pack5(-128, -1, 2, 0, 7), pack5(127, -1, -3, 5, 1), 1'b1);
      wait_got(1, "ts_timeout");
      exp_v = OUTW'(-16254);
      if (got_q.size() >= 1) begin
         check("ts_data", got_q[0].data, exp_v);
         check("ts_ovf", got_q[0].ovf, 0);
      end
`endif

      // Back-pressure with two frames in flight.
      got_q.delete();
      out_ready = 1'b0;
      drive_beat(splat(8'd2), splat(8'd3), 1'b1);
      drive_beat(splat(8'd1), splat(8'd4), 1'b1);
      t = 0;
      while (!out_valid && t < 50) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("stall_result_arrived", out_valid, 1);
      repeat (4) begin
         @(negedge clk);
         check("stall_in_ready", in_ready, 0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_got(2, "t3_timeout");
      if (got_q.size() >= 2) begin
         check("t3_data0", got_q[0].data, 30);
         check("t3_data1", got_q[1].data, 20);
      end

      // Reset mid-frame, then a fresh frame.
      drive_beat(splat(8'd9), splat(8'd9), 1'b0);
      drive_beat(splat(8'd9), splat(8'd9), 1'b0);
      rst_n = 1'b0;
      check_reset_values("midreset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      got_q.delete();
      drive_beat(splat(8'd1), splat(8'd1), 1'b1);
      wait_got(1, "t4_timeout");
      if (got_q.size() >= 1) begin
         check("t4_data", got_q[0].data, 5);
         check("t4_ovf", got_q[0].ovf, 0);
      end

      // Randomized frames with bubbles and random back-pressure.
      fork
         ready_toggler();
         random_frames(40);
      join
      t = 0;
      while (exp_q.size() != 0 && t < 500) begin
         @(posedge clk);
         t++;
      end
      #1;
      check("drain_pending", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
